// File: rtl/collision_defs.sv
// Shared collision definitions: direction codes, screen geometry, default sprite
// and move sizes, and the corner index encoding used by the probe scheduler,
// the collision detector and the movement logic.
package collision_defs;

  // Direction codes; 6 and 7 are unused and behave like DirNoAction.
  typedef enum logic [2:0] {
    DirNoAction = 3'd0,
    DirAttack   = 3'd1,
    DirUp       = 3'd2,
    DirDown     = 3'd3,
    DirLeft     = 3'd4,
    DirRight    = 3'd5
  } dir_e;

  localparam int unsigned SCREEN_W      = 320;
  localparam int unsigned SCREEN_H      = 240;
  localparam int unsigned DEF_SPRITE_PX = 16;
  localparam int unsigned DEF_MOVE_PX   = 1;

  // Probe order within one requester.
  typedef enum logic [1:0] {
    CornerTl = 2'd0,
    CornerTr = 2'd1,
    CornerBl = 2'd2,
    CornerBr = 2'd3
  } corner_e;

  function automatic logic corner_is_right(corner_e c);
    return (c == CornerTr) || (c == CornerBr);
  endfunction

  function automatic logic corner_is_bottom(corner_e c);
    return (c == CornerBl) || (c == CornerBr);
  endfunction

endpackage

// File: rtl/vga_address_translator.sv
// Maps an on-screen pixel coordinate to a linear framebuffer/ROM address.
// Ports:
//   x_i       - pixel column, 0..319
//   y_i       - pixel row, 0..239
//   address_o - y*320 + x
module vga_address_translator (
  input  logic [8:0]  x_i,
  input  logic [7:0]  y_i,
  output logic [16:0] address_o
);

  // y*320 = y*256 + y*64
  assign address_o = {1'b0, y_i, 8'd0} + {3'd0, y_i, 6'd0} + {8'd0, x_i};

endmodule

// File: rtl/map_probe_scheduler.sv
// Shares one levelmap ROM read port among NUM_REQ characters. On start it
// latches every participating character's position/direction, probes the four
// sprite corners displaced by the intended move, and reports one blocked bit
// per character with a done pulse.
// Ports:
//   clock, reset             - clock; asynchronous active-low reset
//   start                    - begin a round (accepted only when idle)
//   req_valid/req_x/req_y/req_dir - packed per-requester inputs, latched at start
//   map_address, map_q       - ROM address out; ROM data in (one-cycle latency)
//   busy, done               - round in progress; one-cycle results-updated pulse
//   map_collision            - per-requester blocked flags, held until next done
module map_probe_scheduler
  import collision_defs::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned SPRITE_PX = DEF_SPRITE_PX,
  parameter int unsigned MOVE_PX   = DEF_MOVE_PX
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [9*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_dir,
  output logic [16:0]          map_address,
  input  logic                 map_q,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_REQ-1:0]   map_collision
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic signed [9:0] MovePx = 10'(MOVE_PX);
  localparam logic signed [9:0] SprOff = 10'(SPRITE_PX - 1);
  localparam logic signed [9:0] ScrW   = 10'(SCREEN_W);
  localparam logic signed [9:0] ScrH   = 10'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StProbe, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   valid_q;
  logic [9*NUM_REQ-1:0] x_q;
  logic [8*NUM_REQ-1:0] y_q;
  logic [3*NUM_REQ-1:0] dir_q;
  logic [IdxW-1:0]      req_q, req_d;
  corner_e              corner_q, corner_d;
  logic [IdxW-1:0]      tag_req_q, tag_req_d;
  logic                 tag_oor_q, tag_oor_d;
  logic                 tag_vld_q, tag_vld_d;
  logic [NUM_REQ-1:0]   acc_q, acc_d;
  logic [NUM_REQ-1:0]   coll_q, coll_d;
  logic                 latch_en;

  logic [8:0]        cur_x;
  logic [7:0]        cur_y;
  logic [2:0]        cur_dir;
  logic signed [9:0] dx, dy, cx, cy;
  logic              oor;
  logic [8:0]        probe_x;
  logic [7:0]        probe_y;
  logic              nxt_found, first_found;
  logic [IdxW-1:0]   nxt_idx, first_idx;

  // Corner generator: current requester's latched state plus move and corner offset.
  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_dir = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (IdxW'(r) == req_q) begin
        cur_x   = x_q[9*r +: 9];
        cur_y   = y_q[8*r +: 8];
        cur_dir = dir_q[3*r +: 3];
      end
    end
    dx = '0;
    dy = '0;
    case (cur_dir)
      DirUp:    dy = -MovePx;
      DirDown:  dy = MovePx;
      DirLeft:  dx = -MovePx;
      DirRight: dx = MovePx;
      default:  ;
    endcase
    cx = $signed({1'b0, cur_x}) + dx + (corner_is_right(corner_q) ? SprOff : 10'sd0);
    cy = $signed({2'b0, cur_y}) + dy + (corner_is_bottom(corner_q) ? SprOff : 10'sd0);
    oor = (cx < 10'sd0) || (cx >= ScrW) || (cy < 10'sd0) || (cy >= ScrH);
    // Off-screen corners still issue a (clamped) read so the cadence is fixed.
    probe_x = (state_q == StProbe && !oor) ? cx[8:0] : '0;
    probe_y = (state_q == StProbe && !oor) ? cy[7:0] : '0;
  end

  // Lowest valid requester above the current one, and lowest valid at start.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int r = NUM_REQ - 1; r >= 0; r--) begin
      if (valid_q[r] && (IdxW'(r) > req_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = IdxW'(r);
      end
      if (req_valid[r]) begin
        first_found = 1'b1;
        first_idx   = IdxW'(r);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    corner_d  = corner_q;
    tag_req_d = '0;
    tag_oor_d = 1'b0;
    tag_vld_d = 1'b0;
    coll_d    = coll_q;
    latch_en  = 1'b0;

    // Merge the ROM answer for the slot issued last cycle.
    acc_d = acc_q;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (tag_vld_q && (IdxW'(r) == tag_req_q) && (tag_oor_q || !map_q)) begin
        acc_d[r] = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_en = 1'b1;
          acc_d    = '0;
          req_d    = first_idx;
          corner_d = CornerTl;
          state_d  = first_found ? StProbe : StDrain;
        end
      end
      StProbe: begin
        tag_vld_d = 1'b1;
        tag_req_d = req_q;
        tag_oor_d = oor;
        if (corner_q == CornerBr) begin
          corner_d = CornerTl;
          if (nxt_found) begin
            req_d = nxt_idx;
          end else begin
            state_d = StDrain;
          end
        end else begin
          corner_d = corner_e'(corner_q + 2'd1);
        end
      end
      StDrain: begin
        coll_d  = acc_d;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= '0;
      req_q     <= '0;
      corner_q  <= CornerTl;
      tag_req_q <= '0;
      tag_oor_q <= 1'b0;
      tag_vld_q <= 1'b0;
      acc_q     <= '0;
      coll_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      corner_q  <= corner_d;
      tag_req_q <= tag_req_d;
      tag_oor_q <= tag_oor_d;
      tag_vld_q <= tag_vld_d;
      acc_q     <= acc_d;
      coll_q    <= coll_d;
      if (latch_en) begin
        valid_q <= req_valid;
        x_q     <= req_x;
        y_q     <= req_y;
        dir_q   <= req_dir;
      end
    end
  end

  vga_address_translator u_addr (
    .x_i      (probe_x),
    .y_i      (probe_y),
    .address_o(map_address)
  );

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign map_collision = coll_q;

endmodule

// File: tb/tb_map_probe_scheduler.sv
module tb_map_probe_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [26:0] req_x = '0;
  logic [23:0] req_y = '0;
  logic [8:0]  req_dir = '0;
  logic [16:0] map_address;
  logic        map_q = 1'b1;
  logic        busy, done;
  logic [2:0]  map_collision;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int blocked_addr = -1;

  typedef struct { logic [2:0] coll; int cyc; } exp_t;
  typedef struct { logic [16:0] addr; int cyc; } aexp_t;
  exp_t        sb_q[$];
  aexp_t       aq[$];
  logic [16:0] pend_addr[$];

  map_probe_scheduler #(.NUM_REQ(3), .SPRITE_PX(16), .MOVE_PX(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_dir      (req_dir),
    .map_address  (map_address),
    .map_q        (map_q),
    .busy         (busy),
    .done         (done),
    .map_collision(map_collision)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Registered ROM: all walkable except one optional address.
  always @(posedge clock) map_q <= (int'(map_address) == blocked_addr) ? 1'b0 : 1'b1;

  // Monitor: checks issued addresses and every done against the scoreboard.
  always @(negedge clock) begin
    if (aq.size() > 0 && aq[0].cyc == cyc) begin
      aexp_t a;
      a = aq.pop_front();
      total++;
      if (map_address !== a.addr) begin
        bad++;
        $display("FAIL addr cyc=%0d got=%0d want=%0d", cyc, map_address, a.addr);
      end
    end
    if (reset && done) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cyc=%0d coll=%b want=no done", cyc, map_collision);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (map_collision !== e.coll || cyc != e.cyc) begin
          bad++;
          $display("FAIL done_result got coll=%b cyc=%0d want coll=%b cyc=%0d",
                   map_collision, cyc, e.coll, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drives one start pulse; cycle k of the round is cyc == c0 + k.
  task automatic start_round(input logic [2:0] v, input logic [26:0] xs, input logic [23:0] ys,
                             input logic [8:0] ds, input int n, input logic [2:0] want,
                             input bit push);
    int c0;
    @(negedge clock);
    c0 = cyc;
    req_valid = v;
    req_x     = xs;
    req_y     = ys;
    req_dir   = ds;
    start     = 1'b1;
    if (push) sb_q.push_back('{want, c0 + 4 * n + 2});
    for (int k = 0; k < pend_addr.size(); k++) aq.push_back('{pend_addr[k], c0 + 1 + k});
    pend_addr.delete();
    @(negedge clock);
    start = 1'b0;
    // Scramble inputs: the round must use latched copies.
    req_x   = '1;
    req_y   = '1;
    req_dir = '1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (sb_q.size() > 0 || aq.size() > 0); i++) @(negedge clock);
    if (sb_q.size() > 0 || aq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout got pending=%0d want=0", sb_q.size() + aq.size());
      sb_q.delete();
      aq.delete();
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    // Reset state.
    idle(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_coll", 32'(map_collision), 0);
    check("rst_addr", 32'(map_address), 0);
    reset = 1'b1;
    idle(10);
    check("idle_busy", 32'(busy), 0);

    // Player (100,50) UP, all walkable.
    pend_addr = '{17'd15780, 17'd15795, 17'd20580, 17'd20595};
    start_round(3'b001, {18'd0, 9'd100}, {16'd0, 8'd50}, {6'd0, 3'd2}, 1, 3'b000, 1);
    wait_drain();

    // Blocked at BR, then at TL.
    blocked_addr = 20595;
    start_round(3'b001, {18'd0, 9'd100}, {16'd0, 8'd50}, {6'd0, 3'd2}, 1, 3'b001, 1);
    wait_drain();
    blocked_addr = 15780;
    start_round(3'b001, {18'd0, 9'd100}, {16'd0, 8'd50}, {6'd0, 3'd2}, 1, 3'b001, 1);
    wait_drain();
    blocked_addr = -1;

    // Enemy1 at x=0 moving LEFT: TL x=-1 off-screen.
    start_round(3'b010, {9'd0, 9'd0, 9'd0}, {8'd0, 8'd50, 8'd0}, {3'd0, 3'd4, 3'd0},
                1, 3'b010, 1);
    wait_drain();

    // Enemy2 y=225 DOWN: bottom corners at y=241.
    start_round(3'b100, {9'd100, 18'd0}, {8'd225, 16'd0}, {3'd3, 6'd0}, 1, 3'b100, 1);
    wait_drain();

    // Player at (304,224) in place: corners reach exactly 319/239.
    pend_addr = '{17'd71984, 17'd71999, 17'd76784, 17'd76799};
    start_round(3'b001, {18'd0, 9'd304}, {16'd0, 8'd224}, {6'd0, 3'd0}, 1, 3'b000, 1);
    wait_drain();

    // Sparse 101: enemy1 would be blocked but is skipped; enemy2 probes in cycles 5..8.
    pend_addr = '{17'd15780, 17'd15795, 17'd20580, 17'd20595,
                  17'd32201, 17'd32216, 17'd37001, 17'd37016};
    start_round(3'b101, {9'd200, 9'd0, 9'd100}, {8'd100, 8'd50, 8'd50},
                {3'd5, 3'd4, 3'd2}, 2, 3'b000, 1);
    wait_drain();

    // No participants.
    start_round(3'b000, '0, '0, '0, 0, 3'b000, 1);
    wait_drain();

    // All three, with a second start during PROBE that must be ignored.
    start_round(3'b111, {9'd100, 9'd0, 9'd100}, {8'd225, 8'd50, 8'd50},
                {3'd3, 3'd4, 3'd2}, 3, 3'b110, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_drain();
    idle(20);
    check("held_coll", 32'(map_collision), 32'b110);

    // Reset mid-PROBE: outputs cleared, no done.
    start_round(3'b111, {9'd100, 9'd0, 9'd100}, {8'd225, 8'd50, 8'd50},
                {3'd3, 3'd4, 3'd2}, 3, 3'b000, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_coll", 32'(map_collision), 0);
    check("midrst_addr", 32'(map_address), 0);
    idle(3);
    reset = 1'b1;
    idle(20);
    check("post_rst_busy", 32'(busy), 0);

    // Fresh round after reset.
    blocked_addr = 15780;
    pend_addr = '{17'd15780, 17'd15795, 17'd20580, 17'd20595};
    start_round(3'b001, {18'd0, 9'd100}, {16'd0, 8'd50}, {6'd0, 3'd2}, 1, 3'b001, 1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_probe_scheduler.md
# map_probe_scheduler

Time-multiplexes a single `levelmap` ROM read port among up to `NUM_REQ` characters (player, enemy1, enemy2) for map-collision checks. It replaces per-corner ROM instances with one port. On each `start` pulse from control it latches every participating character's position and direction, then issues four corner probes per character. It reports one blocked/clear bit per character with a `done` pulse. It sits between the control FSM and the character/enemy movement logic.

## Interface
- `NUM_REQ`, 3: number of requesters; index 0 is the player.
- `SPRITE_PX`, 16: sprite edge length in pixels; corners are at offset 0 and `SPRITE_PX-1`.
- `MOVE_PX`, 1: probe displacement in the movement direction.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  request a check round; sampled only in IDLE.
- `req_valid`  in  NUM_REQ  per-requester participation, latched at start.
- `req_x`  in  9*NUM_REQ  packed x positions; requester r uses bits [9r+8:9r].
- `req_y`  in  8*NUM_REQ  packed y positions.
- `req_dir`  in  3*NUM_REQ  packed direction codes.
- `map_address`  out  17  ROM address, `y*320+x`.
- `map_q`  in  1  ROM data; 1 = walkable; valid one cycle after its address.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when results update.
- `map_collision`  out  NUM_REQ  1 = the requester's next move is blocked; held until the next done.

## Operation
- Direction codes: NO_ACTION=0, ATTACK=1, UP=2, DOWN=3, LEFT=4, RIGHT=5, codes 6–7 are treated as NO_ACTION.
- Displacement:
  - UP: dy=-MOVE_PX.
  - DOWN: dy=+MOVE_PX.
  - LEFT: dx=-MOVE_PX.
  - RIGHT: dx=+MOVE_PX.
  - Otherwise dx=dy=0 (probe in place).
- Corner order per requester: TL (x+dx, y+dy), TR (+SPRITE_PX-1, +0), BL (+0, +SPRITE_PX-1), BR (+SPRITE_PX-1, +SPRITE_PX-1).
- Arithmetic: compute corners in 10-bit signed. A corner is out-of-range if x<0, x≥320, y<0 or y≥240.
  - An out-of-range corner is forced blocked; `map_q` for that slot is ignored.
  - The address still issues, clamped to 0, so timing is unchanged.
- The requester's bit = OR over its 4 corners of (out-of-range OR !map_q).
- Requesters with `req_valid[r]=0` consume no probe cycles and report 0.
- FSM:
  - IDLE: on start=1 → latch inputs, clear accumulators, → PROBE (or DRAIN if no requester is valid).
  - PROBE: present one corner address per cycle, iterating requester r ascending (valid only), corner TL..BR. After the last corner → DRAIN.
  - DRAIN: absorb the final `map_q`; at the end of the cycle load `map_collision` from the accumulators → DONE.
  - DONE: done=1, busy=1 → IDLE.
- Tag pipeline: a one-stage register carries (requester index, out-of-range flag, valid) alongside each issued address. `map_q` is merged into the accumulator selected by the tag.
- `start` outside IDLE is ignored; no queueing.
- Latched inputs are immune to input changes mid-round.

## Timing
- With N valid requesters and start accepted at edge E0:
  - Probe addresses appear in cycles 1..4N.
  - DRAIN is cycle 4N+1.
  - `done` and the new `map_collision` are visible in cycle 4N+2.
  - IDLE follows in cycle 4N+3; a new start is accepted at the edge ending cycle 4N+2? No: start is accepted only in IDLE, i.e. from cycle 4N+3.
- Examples: N=3 → done at cycle 14; N=0 → done at cycle 2.
- `map_address` is driven from registered state only, with no combinational path from inputs.
- Reset (async, any state, including mid-PROBE):
  - state=IDLE, busy=0, done=0, map_collision=0, map_address=0, accumulators and tag cleared.
  - The round is abandoned with no done.

## Structure
- Shared package/include `collision_defs`: direction codes, SCREEN_W=320, SCREEN_H=240, default SPRITE_PX and MOVE_PX, and the corner index encoding. The collision detector and movement logic use the same package.
- One natural sub-module: the existing `vga_address_translator`, instantiated once on the registered, clamped corner coordinates.
- The FSM, corner generator, tag register and accumulators stay in this module.

## Test plan
- Reset: hold reset=0 → all outputs 0; release, idle 10 cycles → busy=0, done never pulses.
- Player (100,50) UP, req_valid=001, ROM all-1 → addresses for (100,49),(115,49),(100,64),(115,64) in cycles 1–4; done at cycle 6; map_collision=000.
- Same as above, but the ROM model returns 0 at (115,64) → map_collision=001. Repeat with 0 at the TL address → 001.
- Boundary cases:
  - Enemy1 at x=0 LEFT → bit1=1 with ROM all-1.
  - Enemy2 y=225 DOWN (BL y=241) → bit2=1.
  - Player at (304,224) NO_ACTION → 0, since corners 319/239 are in range.
- Sparse round: req_valid=101 → 8 probe cycles, done at cycle 10, bit1=0. req_valid=000 → done at cycle 2, map_collision=000.
- Robustness:
  - start pulsed again during PROBE → ignored, single done.
  - reset=0 mid-PROBE → outputs cleared, no done.
  - After release, a fresh start completes normally with correct results.
